fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of FIFO read data and output stream data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning depth of the attached asynchronous FIFO; CNT_W = clogb2(FIFO_DEPTH-1)+1.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning words per burst; legal range 1..FIFO_DEPTH.
REQ-004 rd_clk  input  1  single clock, the FIFO read-side clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 burst_en  input  1  permits new bursts to start.
REQ-007 rd_en  output  1  FIFO read request.
REQ-008 dout  input  DATA_WIDTH  FIFO read data, meaningful when valid=1.
REQ-009 valid  input  1  FIFO read-data qualifier, one cycle after accepted rd_en.
REQ-010 empty  input  1  FIFO empty flag.
REQ-011 rd_count  input  CNT_W  FIFO read-side occupancy.
REQ-012 m_data  output  DATA_WIDTH  stream data.
REQ-013 m_valid  output  1  stream data valid.
REQ-014 m_ready  input  1  downstream accept.
REQ-015 m_last  output  1  marks the final word of a burst.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 rd_err  output  1  one-cycle pulse on valid=1 with no read outstanding.

Function
REQ-018 State machine SHALL have states IDLE, BURST, DRAIN.
REQ-019 IDLE -> BURST when burst_en=1 and rd_count >= BURST_LEN; issued and returned word counters cleared on entry.
REQ-020 BURST: rd_en = !empty && issued < BURST_LEN && (occ + inflight - pop) < 2, where occ is skid-buffer occupancy, inflight is rd_en of the previous cycle and pop is m_valid && m_ready.
REQ-021 rd_en SHALL never be asserted while empty=1 or outside BURST.
REQ-022 BURST -> DRAIN on the cycle the BURST_LEN-th rd_en is issued.
REQ-023 DRAIN -> IDLE on the cycle the word with m_last=1 is accepted (m_valid && m_ready).
REQ-024 Read latency is 1 cycle: valid=1 and dout captured one cycle after rd_en. The word is pushed into the 2-entry skid buffer and m_valid rises the next cycle, so first rd_en to first m_valid is 2 cycles.
REQ-025 With m_ready held 1 and FIFO not empty, throughput SHALL be 1 word per cycle.
REQ-026 m_data/m_last SHALL be stable while m_valid=1 and m_ready=0; no word lost or duplicated.
REQ-027 m_last SHALL be 1 only on the BURST_LEN-th output word of a burst; for BURST_LEN=1, on every burst word.
REQ-028 Stall: empty rising mid-burst holds rd_en low; the burst resumes without restart when empty falls.
REQ-029 valid=1 with inflight=0: data discarded, rd_err pulses, state unchanged.
REQ-030 burst_en falling mid-burst SHALL NOT abort the current burst; it only blocks the next one.
REQ-031 Internal counters SHALL be clogb2(BURST_LEN)+1 bits wide and saturate at BURST_LEN.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, counters 0, buffer empty, and rd_en, m_valid, m_last, busy, rd_err to 0, m_data to 0.
REQ-033 Reset mid-burst SHALL drop buffered words; after release, no rd_en before IDLE->BURST re-qualifies.

Structure
REQ-034 Package fifo_pkg SHALL hold the clogb2 function and the rd_state_t enum (IDLE, BURST, DRAIN).
REQ-035 The 2-entry skid buffer SHALL be a sub-module skid_buf2 (push/data in, valid/ready out, occupancy out).

Verification
REQ-036 FIFO preloaded 1,2,3,4 (rd_count=4), burst_en=1, m_ready=1 -> 4 consecutive rd_en; m_data 1,2,3,4 on consecutive cycles, m_last on 4; rd_count=3 -> no rd_en.
REQ-037 rd_count=4, m_ready=0 -> exactly 2 rd_en, m_valid held with m_data=1; m_ready=1 -> 1,2,3,4 delivered, none lost.
REQ-038 empty=1 after 2 reads for 5 cycles -> rd_en low for those cycles; output 1,2,3,4 with m_last only on 4.
REQ-039 rd_count=8, burst_en=1 -> two bursts 1..4 and 5..8, m_last on 4 and 8, busy low at least 1 cycle between bursts.
REQ-040 rst_n pulsed low after 2nd word delivered -> all outputs 0 asynchronously; after release with rd_count=4, a fresh burst starts.
REQ-041 valid=1 injected in IDLE -> rd_err single pulse, m_valid stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO burst reader.
//   clogb2     : ceil(log2(value)), 0 for value <= 1; used to size counters.
//   rd_state_t : burst reader state encoding.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } rd_state_t;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write one word (ignored when full and not popping)
//   valid_o/ready_i/data_o : stream side, data_o is the head entry
//   occ_o         : current occupancy (0..2)
module skid_buf2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d, occ_mid;
  logic             pop;

  assign pop = (occ_q != 2'd0) && ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_mid = occ_q - {1'b0, pop};
    if (pop && (occ_q == 2'd2)) begin
      head_d = tail_q;
    end
    occ_d = occ_mid;
    // The reader's flow control never pushes into a full buffer; drop it if it happens.
    if (push_i && (occ_mid != 2'd2)) begin
      if (occ_mid == 2'd0) begin
        head_d = data_i;
      end else begin
        tail_d = data_i;
      end
      occ_d = occ_mid + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Reads fixed-length bursts from the read side of an asynchronous FIFO and
// presents them as a ready/valid stream with an end-of-burst marker.
//   rd_clk, rst_n         : read-side clock, asynchronous active-low reset
//   burst_en              : permits a new burst to start
//   rd_en/dout/valid      : FIFO read request, read data, data qualifier (1-cycle latency)
//   empty/rd_count        : FIFO empty flag and read-side occupancy
//   m_data/m_valid/m_ready/m_last : output stream, m_last on the final word of a burst
//   busy                  : high while a burst is being read or drained
//   rd_err                : one-cycle pulse when valid arrives with no read outstanding
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                            rd_clk,
  input  logic                            rst_n,
  input  logic                            burst_en,
  output logic                            rd_en,
  input  logic [DATA_WIDTH-1:0]           dout,
  input  logic                            valid,
  input  logic                            empty,
  input  logic [clogb2(FIFO_DEPTH-1):0]   rd_count,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
  output logic                            busy,
  output logic                            rd_err
);

  localparam int unsigned CNT_W = clogb2(FIFO_DEPTH - 1) + 1;
  localparam int unsigned CW    = clogb2(BURST_LEN) + 1;

  localparam logic [CW-1:0]    BurstLenC  = CW'(BURST_LEN);
  localparam logic [CW-1:0]    BurstLastC = CW'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BurstLenRd = CNT_W'(BURST_LEN);

  rd_state_t       state_q, state_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   pushed_q, pushed_d;
  logic            inflight_q;
  logic            busy_q, busy_d;
  logic            rd_err_q, rd_err_d;

  logic            push;
  logic            pop;
  logic            last_tag;
  logic [1:0]      occ;
  logic [DATA_WIDTH:0] skid_out;

  // A returned word is only accepted when it answers a read issued last cycle.
  assign push     = valid && inflight_q;
  assign pop      = m_valid && m_ready;
  assign last_tag = (pushed_q == BurstLastC);

  // Never let buffered plus in-flight words exceed the two skid slots.
  assign rd_en = (state_q == BURST) && !empty && (issued_q < BurstLenC) &&
                 (({1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    pushed_d = pushed_q;
    if (rd_en) begin
      issued_d = issued_q + CW'(1);
    end
    if (push && (pushed_q < BurstLenC)) begin
      pushed_d = pushed_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (burst_en && (rd_count >= BurstLenRd)) begin
          state_d  = BURST;
          issued_d = '0;
          pushed_d = '0;
        end
      end
      BURST: begin
        if (rd_en && (issued_q == BurstLastC)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    rd_err_d = valid && !inflight_q;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      pushed_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      pushed_q   <= pushed_d;
      inflight_q <= rd_en;
      busy_q     <= busy_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Each word carries its end-of-burst flag through the buffer.
  skid_buf2 #(
    .Width(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i  (rd_clk),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i ({last_tag, dout}),
    .valid_o(m_valid),
    .ready_i(m_ready),
    .data_o (skid_out),
    .occ_o  (occ)
  );

  assign m_data = skid_out[DATA_WIDTH-1:0];
  assign m_last = skid_out[DATA_WIDTH];
  assign busy   = busy_q;
  assign rd_err = rd_err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int unsigned BL    = 4;
  localparam int unsigned CNT_W = 4;

  logic             rd_clk = 1'b0;
  logic             rst_n;
  logic             burst_en;
  logic             rd_en;
  logic [7:0]       dout;
  logic             valid;
  logic             empty;
  logic [CNT_W-1:0] rd_count;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             busy;
  logic             rd_err;

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(8),
    .BURST_LEN (BL)
  ) dut (
    .rd_clk  (rd_clk),
    .rst_n   (rst_n),
    .burst_en(burst_en),
    .rd_en   (rd_en),
    .dout    (dout),
    .valid   (valid),
    .empty   (empty),
    .rd_count(rd_count),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .rd_err  (rd_err)
  );

  always #5 rd_clk = ~rd_clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge rd_clk) cyc <= cyc + 1;

  // FIFO model
  logic [7:0] fifo_q[$];
  int         fifo_n      = 0;
  logic       force_empty = 1'b0;
  logic       inject      = 1'b0;
  logic       rd_seen     = 1'b0;
  int unsigned rd_idx     = 0;

  assign empty    = (fifo_n == 0) || force_empty;
  assign rd_count = CNT_W'(fifo_n);

  // Scoreboard: words come out in read order, every BL-th word since reset is last.
  logic [7:0]  exp_data[$];
  logic        exp_last[$];
  logic [7:0]  got_data[$];
  logic        got_last[$];
  int unsigned got_cyc[$];
  int unsigned rd_cyc[$];

  logic       hold_v = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge rd_clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (rd_en) chk("rd_en_gate", {30'd0, empty, !busy}, 32'd0);
      if (hold_v) chk("hold_stable", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, hold_last, hold_data});
      if (m_valid) begin
        chk("word_expected", 32'(exp_data.size() == 0), 32'd0);
        if (exp_data.size() > 0) begin
          chk("m_data", 32'(m_data), 32'(exp_data[0]));
          chk("m_last", 32'(m_last), 32'(exp_last[0]));
        end
        if (m_ready) begin
          got_data.push_back(m_data);
          got_last.push_back(m_last);
          got_cyc.push_back(cyc);
          if (exp_data.size() > 0) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end
      hold_v    = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end
  end

  task automatic tick();
    logic [7:0] d;
    @(negedge rd_clk);
    rd_seen = rd_en;
    if (rd_seen) rd_cyc.push_back(cyc);
    @(posedge rd_clk);
    #1;
    valid = 1'b0;
    if (rd_seen && rst_n) begin
      chk("read_from_empty", 32'(fifo_n == 0), 32'd0);
      if (fifo_n > 0) begin
        d = fifo_q.pop_front();
        fifo_n--;
        dout  = d;
        valid = 1'b1;
        exp_data.push_back(d);
        exp_last.push_back((rd_idx % BL) == BL - 1);
        rd_idx++;
      end
    end else if (inject) begin
      valid  = 1'b1;
      dout   = 8'hEE;
      inject = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic preload(input int first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + i));
    fifo_n = fifo_n + n;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    rd_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0; dout = 8'h00; inject = 1'b0; force_empty = 1'b0;
    burst_en = 1'b0; m_ready = 1'b0;
    fifo_q.delete(); fifo_n = 0; rd_idx = 0;
    exp_data.delete(); exp_last.delete();
    clear_logs();
    repeat (2) @(posedge rd_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Delivered stream must be first..first+n-1 with m_last on every BL-th word.
  task automatic check_stream(input string name, input int first, input int n);
    chk({name, "_count"}, 32'(got_data.size()), 32'(n));
    if (got_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_data"}, 32'(got_data[i]), 32'(first + i));
        chk({name, "_last"}, 32'(got_last[i]), 32'((i % BL) == BL - 1));
      end
    end
  endtask

  initial begin
    int phase;
    int gap;
    int nerr;
    int nval;

    rst_n = 1'b0; burst_en = 1'b0; m_ready = 1'b0; valid = 1'b0; dout = 8'h00;
    #1;
    chk("reset_state", {21'd0, rd_en, m_valid, m_last, busy, rd_err, m_data}, 32'd0);
    do_reset();

    // 1: back-to-back burst of 1..4, then a 3-word FIFO must not start a burst.
    preload(1, 4);
    burst_en = 1'b1; m_ready = 1'b1;
    ticks(12);
    chk("t1_rd_count", 32'(rd_cyc.size()), 32'd4);
    if (rd_cyc.size() == 4) chk("t1_rd_back_to_back", rd_cyc[3] - rd_cyc[0], 32'd3);
    if (got_cyc.size() == 4 && rd_cyc.size() == 4) begin
      chk("t1_first_latency", got_cyc[0] - rd_cyc[0], 32'd2);
      chk("t1_out_back_to_back", got_cyc[3] - got_cyc[0], 32'd3);
    end
    if (got_data.size() == 4) begin
      chk("t1_lit_w0", 32'(got_data[0]), 32'd1);
      chk("t1_lit_w3", 32'(got_data[3]), 32'd4);
      chk("t1_lit_last3", 32'(got_last[3]), 32'd1);
      chk("t1_lit_last2", 32'(got_last[2]), 32'd0);
    end
    check_stream("t1", 1, 4);
    chk("t1_idle", 32'(busy), 32'd0);
    clear_logs();
    preload(5, 3);
    ticks(8);
    chk("t1_short_no_rd", 32'(rd_cyc.size()), 32'd0);
    chk("t1_short_idle", 32'(busy), 32'd0);

    // 2: backpressure holds the first word with only two reads issued.
    do_reset();
    preload(1, 4);
    burst_en = 1'b1; m_ready = 1'b0;
    ticks(10);
    chk("t2_rd_limited", 32'(rd_cyc.size()), 32'd2);
    chk("t2_held", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'd1});
    m_ready = 1'b1;
    ticks(10);
    chk("t2_rd_total", 32'(rd_cyc.size()), 32'd4);
    check_stream("t2", 1, 4);
    chk("t2_drained", 32'(exp_data.size()), 32'd0);

    // 3: empty stall after two reads, then resume.
    do_reset();
    preload(1, 4);
    burst_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30 && rd_cyc.size() < 2; i++) tick();
    chk("t3_two_reads", 32'(rd_cyc.size()), 32'd2);
    force_empty = 1'b1;
    ticks(5);
    chk("t3_stalled", 32'(rd_cyc.size()), 32'd2);
    chk("t3_busy_in_stall", 32'(busy), 32'd1);
    force_empty = 1'b0;
    ticks(12);
    check_stream("t3", 1, 4);

    // 4: two consecutive bursts with an idle gap between them.
    do_reset();
    preload(1, 8);
    burst_en = 1'b1; m_ready = 1'b1;
    phase = 0; gap = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (phase == 0 && busy) phase = 1;
      else if (phase == 1 && !busy) begin phase = 2; gap = 1; end
      else if (phase == 2 && !busy) gap++;
      else if (phase == 2 && busy) phase = 3;
    end
    chk("t4_second_burst", 32'(phase), 32'd3);
    chk("t4_gap", 32'(gap >= 1), 32'd1);
    chk("t4_rd_total", 32'(rd_cyc.size()), 32'd8);
    check_stream("t4", 1, 8);

    // 5: asynchronous reset mid-burst, then a fresh burst.
    do_reset();
    preload(1, 4);
    burst_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 30 && got_data.size() < 2; i++) tick();
    chk("t5_two_out", 32'(got_data.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset", {21'd0, rd_en, m_valid, m_last, busy, rd_err, m_data}, 32'd0);
    do_reset();
    burst_en = 1'b1; m_ready = 1'b1;
    ticks(3);
    chk("t5_no_rd_after_release", 32'(rd_cyc.size()), 32'd0);
    preload(9, 4);
    ticks(14);
    check_stream("t5", 9, 4);
    if (got_data.size() == 4) chk("t5_lit_w3", 32'(got_data[3]), 32'd12);

    // 6: stray valid in IDLE.
    do_reset();
    inject = 1'b1;
    tick();
    nerr = 0; nval = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_err) nerr++;
      if (m_valid) nval++;
    end
    chk("t6_rd_err_pulses", 32'(nerr), 32'd1);
    chk("t6_no_m_valid", 32'(nval), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
